// File: rtl/adder_pkg.sv
// Shared constants and lane-count limits for the adder primitive family
// (half adder, full adder, ripple/parallel adder chains).
package adder_pkg;

  typedef int unsigned lane_count_t;

  localparam lane_count_t LANES_MIN = 1;
  localparam lane_count_t LANES_MAX = 1024;

  // Reset values for registered adder outputs; every result bit clears to zero.
  localparam logic RST_SUM   = 1'b0;
  localparam logic RST_COUT  = 1'b0;
  localparam logic RST_VALID = 1'b0;

  function automatic bit lanes_in_range(input lane_count_t n);
    return (n >= LANES_MIN) && (n <= LANES_MAX);
  endfunction

endpackage

// File: rtl/half_adder_core_if.sv
// Operand/result bundle for the lane-parallel half adder: the master drives
// operands and observes results, the slave (the core) does the reverse.
interface half_adder_core_if
  import adder_pkg::*;
#(
  parameter lane_count_t LANES = 1
);

  logic             in_valid;
  logic [LANES-1:0] A;
  logic [LANES-1:0] B;
  logic             out_valid;
  logic [LANES-1:0] Sum;
  logic [LANES-1:0] Cout;

  modport master (
    output in_valid, A, B,
    input  out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, Sum, Cout
  );

endinterface

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder: {Cout,Sum} = A + B.
module half_adder_cell (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B;
  assign Cout = A & B;

endmodule

// File: rtl/half_adder_core.sv
// Registered, lane-parallel half adder: one combinational cell per lane
// feeding an output register bank qualified by a valid flop.
module half_adder_core
  import adder_pkg::*;
#(
  parameter lane_count_t LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  half_adder_core_if.slave         bus
);

  logic [LANES-1:0] sum_c;
  logic [LANES-1:0] cout_c;
  logic [LANES-1:0] sum_d;
  logic [LANES-1:0] cout_d;
  logic [LANES-1:0] sum_q;
  logic [LANES-1:0] cout_q;
  logic             valid_d;
  logic             valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    half_adder_cell u_cell (
      .A    (bus.A[gi]),
      .B    (bus.B[gi]),
      .Sum  (sum_c[gi]),
      .Cout (cout_c[gi])
    );
  end

  // Idle cycles select the held value, so unknown operands never reach the bank.
  always_comb begin
    valid_d = bus.in_valid;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (bus.in_valid) begin
      sum_d  = sum_c;
      cout_d = cout_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= {LANES{RST_SUM}};
      cout_q  <= {LANES{RST_COUT}};
      valid_q <= RST_VALID;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_half_adder_core.sv
// Self-checking bench: three cores (1, 4 and 8 lanes) against an arithmetic
// reference model that derives each lane's result from A[i] + B[i].
module tb_half_adder_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  half_adder_core_if #(.LANES(1)) bus1 ();
  half_adder_core_if #(.LANES(4)) bus4 ();
  half_adder_core_if #(.LANES(8)) bus8 ();

  half_adder_core #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  half_adder_core #(.LANES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  half_adder_core #(.LANES(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int tests_run    = 0;
  int tests_failed = 0;

  int       lane_cnt [3] = '{1, 4, 8};
  bit       pend_v   [3];
  bit [7:0] pend_a   [3];
  bit [7:0] pend_b   [3];
  bit       exp_v    [3];
  bit [7:0] exp_sum  [3];
  bit [7:0] exp_cout [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs_sum(input int d);
    case (d)
      0:       return {7'b0, bus1.Sum};
      1:       return {4'b0, bus4.Sum};
      default: return bus8.Sum;
    endcase
  endfunction

  function automatic logic [7:0] obs_cout(input int d);
    case (d)
      0:       return {7'b0, bus1.Cout};
      1:       return {4'b0, bus4.Cout};
      default: return bus8.Cout;
    endcase
  endfunction

  function automatic logic obs_valid(input int d);
    case (d)
      0:       return bus1.out_valid;
      1:       return bus4.out_valid;
      default: return bus8.out_valid;
    endcase
  endfunction

  task automatic drive(input int d, input bit v, input bit [7:0] a, input bit [7:0] b);
    pend_v[d] = v;
    pend_a[d] = a;
    pend_b[d] = b;
    case (d)
      0: begin bus1.in_valid = v; bus1.A = a[0:0]; bus1.B = b[0:0]; end
      1: begin bus4.in_valid = v; bus4.A = a[3:0]; bus4.B = b[3:0]; end
      default: begin bus8.in_valid = v; bus8.A = a; bus8.B = b; end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      exp_v[d]    = 1'b0;
      exp_sum[d]  = '0;
      exp_cout[d] = '0;
    end
  endtask

  // Reference: each lane's 2-bit total a+b splits into carry (/2) and sum (%2).
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      exp_v[d] = pend_v[d];
      if (pend_v[d]) begin
        for (int i = 0; i < lane_cnt[d]; i++) begin
          int total;
          total          = int'(pend_a[d][i]) + int'(pend_b[d][i]);
          exp_sum[d][i]  = (total % 2) != 0;
          exp_cout[d][i] = (total / 2) != 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_l%0d_valid", tag, lane_cnt[d]), {31'b0, obs_valid(d)}, {31'b0, exp_v[d]});
      check_eq($sformatf("%s_l%0d_sum",   tag, lane_cnt[d]), {24'b0, obs_sum(d)},   {24'b0, exp_sum[d]});
      check_eq($sformatf("%s_l%0d_cout",  tag, lane_cnt[d]), {24'b0, obs_cout(d)},  {24'b0, exp_cout[d]});
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    bit [1:0] ab_pair;
    bit [7:0] ra;
    bit [7:0] rb;

    idle_all();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    tick("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive single-lane truth table, back-to-back.
    for (int k = 0; k < 4; k++) begin
      ab_pair = 2'(k);
      drive(0, 1'b1, {7'b0, ab_pair[1]}, {7'b0, ab_pair[0]});
      tick($sformatf("exh%0d", k));
    end
    check_eq("exh11_cout_const", {31'b0, bus1.Cout}, 32'd1);
    check_eq("exh11_sum_const",  {31'b0, bus1.Sum},  32'd0);

    // Produce Sum=1,Cout=0, then idle with A=B=1: result must hold.
    drive(0, 1'b1, 8'h01, 8'h00);
    tick("pre_gate");
    drive(0, 1'b0, 8'h01, 8'h01);
    tick("gate");
    check_eq("gate_sum_const",   {31'b0, bus1.Sum},       32'd1);
    check_eq("gate_valid_const", {31'b0, bus1.out_valid}, 32'd0);

    // Async reset between edges while Cout=1.
    drive(0, 1'b1, 8'h01, 8'h01);
    tick("pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    drive(0, 1'b1, 8'h01, 8'h01);
    tick("rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 8'h01, 8'h00);
    tick("rst_release");
    check_eq("release_sum_const", {31'b0, bus1.Sum}, 32'd1);

    // Four-lane directed pattern.
    idle_all();
    drive(1, 1'b1, 8'h0C, 8'h0A);
    tick("l4");
    check_eq("l4_sum_const",  {28'b0, bus4.Sum},  32'h6);
    check_eq("l4_cout_const", {28'b0, bus4.Cout}, 32'h8);

    // Random traffic on all cores; the 8-lane core runs back-to-back.
    for (int c = 0; c < 1000; c++) begin
      for (int d = 0; d < 3; d++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        drive(d, (d == 2) ? 1'b1 : ($urandom_range(0, 3) != 0), ra, rb);
      end
      tick($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/half_adder_core.md
# half_adder_core

Registered, lane-parallel half adder: each lane adds two 1-bit operands and produces a 1-bit sum and a 1-bit carry. It is the leaf arithmetic primitive of the combinational-circuits library, wrapped with an output register stage and a valid qualifier so it can sit directly in a clocked datapath. It is the building block for full adders and ripple/parallel adder chains.

## Interface

Parameters:
- LANES, default 1: number of independent 1-bit half-adder lanes (min 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronised by the integrator.
- in_valid  input  1  A/B are valid this cycle.
- A  input  LANES  operand A, one bit per lane.
- B  input  LANES  operand B, one bit per lane.
- out_valid  output  1  Sum/Cout hold a result.
- Sum  output  LANES  per-lane sum, A[i] XOR B[i].
- Cout  output  LANES  per-lane carry, A[i] AND B[i].

## Operation

- Per lane i: Sum[i] = A[i] ^ B[i]; Cout[i] = A[i] & B[i]. Lanes are fully independent; no carry propagates between lanes.
- Truth table per lane (A,B -> Sum,Cout): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Invariant: {Cout[i],Sum[i]} == A[i] + B[i] (2-bit unsigned result).
- On a rising edge with in_valid=1, register Sum/Cout from the current A/B and set out_valid=1.
- On a rising edge with in_valid=0, clear out_valid to 0 and hold Sum/Cout at their previous values.
- There is no backpressure. Every accepted input produces exactly one result, and a new result overwrites the previous one.
- X on A/B while in_valid=0 must not propagate into Sum/Cout.

## Timing

- Latency 1 cycle: inputs sampled at edge N appear on Sum/Cout/out_valid after edge N and remain stable until edge N+1.
- Throughput: one result per lane per cycle, back-to-back.
- Reset (rst_n=0): Sum, Cout and out_valid go to 0 immediately, without waiting for a clock edge, and stay 0 while rst_n is low.
- Reset asserted mid-stream: any in-flight result is discarded.
- First edge after rst_n rises with in_valid=1: normal capture, no extra bubble.
- The combinational path (in-lane XOR/AND) must fit in one clock with margin. The output register is the only sequential element.

## Structure

- Sub-module half_adder_cell: purely combinational 1-bit cell with ports A, B, Sum, Cout. Instantiate it LANES times via generate.
- half_adder_core: owns the generate loop, the output register bank and the valid flop.
- Shared package adder_pkg: reset-value constants (all zeros) and the lane-count type/limits. It is reused by full_adder and ripple-adder blocks.

## Test plan

- Exhaustive, LANES=1, in_valid=1: A,B = 00,01,10,11 on consecutive cycles -> one cycle later Sum,Cout = 0,0; 1,0; 1,0; 0,1, with out_valid=1 throughout.
- Valid gating: in_valid=0 with A=1,B=1 after a result of Sum=1,Cout=0 -> out_valid=0; Sum stays 1, Cout stays 0.
- Async reset: assert rst_n=0 between clock edges while Cout=1 -> Sum, Cout and out_valid drop to 0 before the next edge and hold at 0 while reset is low.
- Reset release: deassert rst_n, then apply in_valid=1, A=1, B=0 -> after the next edge Sum=1, Cout=0, out_valid=1.
- LANES=4: A=4'b1100, B=4'b1010 -> Sum=4'b0110, Cout=4'b1000 one cycle later.
- Random back-to-back, LANES=8, 1000 cycles: every cycle {Cout[i],Sum[i]} equals A[i]+B[i] from the previous cycle.
